// File: rtl/neo_engine.sv
// Nonlinear Energy Operator engine: sweeps a 1-cycle-latency sample memory and
// streams psi[n] = x[n]^2 - x[n-1]*x[n+1] with spike flagging and counting.
module neo_engine #(
   parameter int N = 16,
   parameter int M = 32
) (
   input  logic                   Clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [2*N-1:0]         thresh,
   output logic [$clog2(M)-1:0]   raddr,
   input  logic [N-1:0]           rdata,
   output logic [2*N-1:0]         psi,
   output logic                   psi_valid,
   output logic                   spike,
   output logic [$clog2(M):0]     spike_count,
   output logic                   busy,
   output logic                   done
);

   localparam int AW = $clog2(M);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

   logic [1:0]      state_q, state_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic            issue_q, issue_d;
   logic            rvalid_q, rvalid_d;
   logic [N-1:0]    x0_q, x0_d;
   logic [N-1:0]    x1_q, x1_d;
   logic [N-1:0]    x2_q, x2_d;
   logic [1:0]      fill_q, fill_d;
   logic            comp_q, comp_d;
   logic [2*N-1:0]  psi_q, psi_d;
   logic            psi_valid_q, psi_valid_d;
   logic            spike_q, spike_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // Operands widened to 2N bits; the exact result fits, so wrap-around
   // in the intermediate products cancels out in the difference.
   logic signed [2*N-1:0] x0_e, x1_e, x2_e, neo;
   logic                  over;

   always_comb begin
      x0_e = {{N{x0_q[N-1]}}, x0_q};
      x1_e = {{N{x1_q[N-1]}}, x1_q};
      x2_e = {{N{x2_q[N-1]}}, x2_q};
      neo  = x1_e * x1_e - x2_e * x0_e;
      over = neo > $signed(thresh);
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      raddr_d     = raddr_q;
      issue_d     = 1'b0;
      rvalid_d    = issue_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      fill_d      = fill_q;
      comp_d      = 1'b0;
      psi_d       = psi_q;
      psi_valid_d = comp_q;
      spike_d     = 1'b0;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      if (rvalid_q) begin
         x2_d   = x1_q;
         x1_d   = x0_q;
         x0_d   = rdata;
         comp_d = (fill_q >= 2'd2);
         if (fill_q != 2'd3) begin
            fill_d = fill_q + 2'd1;
         end
      end

      if (comp_q) begin
         psi_d   = neo;
         spike_d = over;
         if (over) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               raddr_d = '0;
               issue_d = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
               x0_d    = '0;
               x1_d    = '0;
               x2_d    = '0;
               fill_d  = 2'd0;
            end
         end
         FETCH: begin
            raddr_d = raddr_q + AW'(1);
            issue_d = 1'b1;
            if (raddr_d == LAST_ADDR) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // The last psi has just been registered once the compute strobe drops.
            if (psi_valid_q && !comp_q) begin
               state_d = FINISH;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         raddr_q     <= '0;
         issue_q     <= 1'b0;
         rvalid_q    <= 1'b0;
         x0_q        <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         fill_q      <= 2'd0;
         comp_q      <= 1'b0;
         psi_q       <= '0;
         psi_valid_q <= 1'b0;
         spike_q     <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         issue_q     <= issue_d;
         rvalid_q    <= rvalid_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         fill_q      <= fill_d;
         comp_q      <= comp_d;
         psi_q       <= psi_d;
         psi_valid_q <= psi_valid_d;
         spike_q     <= spike_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign raddr       = raddr_q;
   assign psi         = psi_q;
   assign psi_valid   = psi_valid_q;
   assign spike       = spike_q;
   assign spike_count = cnt_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_neo_engine.sv
// Directed bench for neo_engine: registered sample memory, hand-derived psi
// tables per run, cycle-exact checks of valid/done timing and spike counting.
module tb_neo_engine;

   localparam int N  = 16;
   localparam int M  = 32;
   localparam int AW = $clog2(M);

   logic              Clk = 1'b0;
   logic              reset;
   logic              start;
   logic [2*N-1:0]    thresh;
   logic [AW-1:0]     raddr;
   logic [N-1:0]      rdata;
   logic [2*N-1:0]    psi;
   logic              psi_valid;
   logic              spike;
   logic [AW:0]       spike_count;
   logic              busy;
   logic              done;

   logic [N-1:0]      mem [M];
   longint            exp_psi [M];

   int n_vec  = 0;
   int n_miss = 0;

   neo_engine #(.N(N), .M(M)) dut (
      .Clk         (Clk),
      .reset       (reset),
      .start       (start),
      .thresh      (thresh),
      .raddr       (raddr),
      .rdata       (rdata),
      .psi         (psi),
      .psi_valid   (psi_valid),
      .spike       (spike),
      .spike_count (spike_count),
      .busy        (busy),
      .done        (done)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) rdata <= mem[raddr];

   task automatic check(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " raddr"},       longint'(raddr), 0);
      check({tag, " psi"},         longint'(psi), 0);
      check({tag, " psi_valid"},   longint'(psi_valid), 0);
      check({tag, " spike"},       longint'(spike), 0);
      check({tag, " spike_count"}, longint'(spike_count), 0);
      check({tag, " busy"},        longint'(busy), 0);
      check({tag, " done"},        longint'(done), 0);
   endtask

   // One full run: start sampled at E0, outputs sampled 1 time unit after each edge.
   task automatic do_run(input string name, input int exp_spk, input int restart_edge,
                         input bit restart_on_done, input bit chk_raddr);
      int     nvalid;
      int     first_valid;
      int     done_edge;
      int     ndone;
      int     run_cnt;
      int     n;
      longint th;
      th          = longint'($signed(thresh));
      nvalid      = 0;
      first_valid = -1;
      done_edge   = -1;
      ndone       = 0;
      run_cnt     = 0;
      @(negedge Clk);
      start = 1'b1;
      @(posedge Clk);
      #1;
      check({name, " E0 busy"},        longint'(busy), 1);
      check({name, " E0 raddr"},       longint'(raddr), 0);
      check({name, " E0 spike_count"}, longint'(spike_count), 0);
      @(negedge Clk);
      start = 1'b0;
      for (int e = 1; e <= M + 8; e++) begin
         @(posedge Clk);
         #1;
         if (chk_raddr) begin
            check($sformatf("%s raddr E%0d", name, e), longint'(raddr), (e < M) ? e : M - 1);
         end
         if (psi_valid) begin
            n = e - 4;
            if (first_valid < 0) first_valid = e;
            nvalid++;
            if (n >= 1 && n <= M - 2) begin
               if (exp_psi[n] > th) run_cnt++;
               check($sformatf("%s psi[%0d]", name, n), longint'($signed(psi)), exp_psi[n]);
               check($sformatf("%s spike[%0d]", name, n), longint'(spike), (exp_psi[n] > th) ? 1 : 0);
               check($sformatf("%s count@%0d", name, n), longint'(spike_count), run_cnt);
            end else begin
               check($sformatf("%s psi_valid out of window E%0d", name, e), 1, 0);
            end
         end else begin
            check($sformatf("%s spike w/o valid E%0d", name, e), longint'(spike), 0);
         end
         if (done) begin
            ndone++;
            done_edge = e;
         end
         if (e == M + 2) check({name, " busy before done"}, longint'(busy), 1);
         if (e == M + 3) check({name, " busy at done"}, longint'(busy), 0);
         @(negedge Clk);
         start = ((e + 1) == restart_edge) || (restart_on_done && done);
      end
      start = 1'b0;
      check({name, " valid cycles"}, nvalid, M - 2);
      check({name, " first valid edge"}, first_valid, 5);
      check({name, " done edge"}, done_edge, M + 3);
      check({name, " done pulses"}, ndone, 1);
      check({name, " spike_count"}, longint'(spike_count), exp_spk);
      check({name, " psi held"}, longint'($signed(psi)), exp_psi[M - 2]);
      check({name, " idle busy"}, longint'(busy), 0);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < M; i++) begin
         mem[i]     = N'(i);
         exp_psi[i] = 1;
      end
   endtask

   task automatic load_alt();
      for (int i = 0; i < M; i++) begin
         mem[i]     = (i % 2 == 0) ? 16'h7fff : 16'h8000;
         exp_psi[i] = (i % 2 == 0) ? -65535 : 65535;
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      thresh = '0;
      for (int i = 0; i < M; i++) begin
         mem[i]     = '0;
         exp_psi[i] = 0;
      end
      repeat (3) @(negedge Clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      repeat (2) @(negedge Clk);

      for (int i = 0; i < M; i++) begin
         mem[i]     = 16'd5;
         exp_psi[i] = 0;
      end
      thresh = 32'sd0;
      do_run("const5", 0, -1, 1'b0, 1'b1);

      load_ramp();
      thresh = 32'sd0;
      do_run("ramp_t0", 30, -1, 1'b0, 1'b1);

      thresh = 32'sd1;
      do_run("ramp_t1", 0, -1, 1'b0, 1'b0);

      thresh = -32'sd1;
      do_run("ramp_tm1", 30, -1, 1'b0, 1'b0);

      load_alt();
      thresh = 32'sd0;
      do_run("alt", 15, -1, 1'b0, 1'b0);

      // Break the pattern at sample 2 to hit the largest positive psi.
      load_alt();
      mem[2]     = 16'h8000;
      exp_psi[1] = 2147450880;
      exp_psi[2] = 0;
      exp_psi[3] = 2147450880;
      do_run("extreme", 15, -1, 1'b0, 1'b0);

      load_ramp();
      thresh = 32'sd0;
      do_run("restart", 30, 10, 1'b1, 1'b1);

      // Abort a run with reset just after E12.
      @(negedge Clk);
      start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      start = 1'b0;
      repeat (12) @(posedge Clk);
      #1;
      check("abort valid before reset", longint'(psi_valid), 1);
      check("abort count before reset", longint'(spike_count), 8);
      #1;
      reset = 1'b1;
      #1;
      check_idle_outputs("abort");
      begin
         int ndone;
         ndone = 0;
         repeat (4) begin
            @(posedge Clk);
            #1;
            if (done) ndone++;
         end
         check("abort done pulses", ndone, 0);
      end
      @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);
      check_idle_outputs("after abort");
      do_run("post_abort", 30, -1, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
